// File: rtl/apb_reg_bridge.sv
// APB3 completer bridging each transfer to a single-beat request on the simple
// register port, with read-latency wait states and PSLVERR on bad or stalled accesses.
module apb_reg_bridge #(
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        reg_en_o,
  output logic [31:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic        reg_we_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ready_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int LAT_W   = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam int STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(RD_LATENCY);
  // Last stalled cycle before abort; the abort edge is the TIMEOUT-th stalled one.
  localparam logic [STALL_W-1:0] STALL_LAST = (TIMEOUT > 0) ? STALL_W'(TIMEOUT - 1) : '0;

  logic [1:0]         state_reg, state_next;
  logic [31:0]        addr_reg, addr_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic               write_reg, write_next;
  logic               err_reg, err_next;
  logic [31:0]        prdata_reg, prdata_next;
  logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic               bad_xfer;

  assign bad_xfer = (paddr_i[1:0] != 2'b00) || (pwrite_i && (pstrb_i != 4'hF));

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    write_next     = write_reg;
    err_next       = err_reg;
    prdata_next    = prdata_reg;
    lat_cnt_next   = lat_cnt_reg;
    stall_cnt_next = stall_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          addr_next      = paddr_i;
          wdata_next     = pwdata_i;
          write_next     = pwrite_i;
          prdata_next    = '0;
          lat_cnt_next   = '0;
          stall_cnt_next = '0;
          err_next       = bad_xfer;
          state_next     = bad_xfer ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (reg_ready_i) begin
          if (write_reg) begin
            state_next = ST_DONE;
          end else if (RD_LATENCY == 0) begin
            prdata_next = reg_rdata_i;
            state_next  = ST_DONE;
          end else begin
            lat_cnt_next = LAT_W'(1);
            state_next   = ST_RDWAIT;
          end
        end else if (TIMEOUT > 0) begin
          if (stall_cnt_reg == STALL_LAST) begin
            err_next    = 1'b1;
            prdata_next = '0;
            state_next  = ST_DONE;
          end else begin
            stall_cnt_next = stall_cnt_reg + STALL_W'(1);
          end
        end
      end
      ST_RDWAIT: begin
        if (lat_cnt_reg == LAT_LAST) begin
          prdata_next = reg_rdata_i;
          state_next  = ST_DONE;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      write_reg     <= 1'b0;
      err_reg       <= 1'b0;
      prdata_reg    <= '0;
      lat_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      write_reg     <= write_next;
      err_reg       <= err_next;
      prdata_reg    <= prdata_next;
      lat_cnt_reg   <= lat_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Response fields are forced to zero outside the single DONE cycle.
  assign pready_o    = (state_reg == ST_DONE);
  assign pslverr_o   = pready_o && err_reg;
  assign prdata_o    = pready_o ? prdata_reg : 32'h0;
  assign reg_en_o    = (state_reg == ST_ISSUE);
  assign reg_we_o    = reg_en_o && write_reg;
  assign reg_addr_o  = addr_reg;
  assign reg_wdata_o = wdata_reg;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Bench for apb_reg_bridge: directed and random APB transfers against a memory-backed
// target, with expected timing/data/error derived from the transfer rules.
module tb_apb_reg_bridge;

  localparam int RD_LATENCY = 1;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic        reg_en_o, reg_we_o;
  logic [31:0] reg_addr_o, reg_wdata_o;
  logic [31:0] reg_rdata_i;
  logic        reg_ready_i;

  always #5 clk = ~clk;

  apb_reg_bridge #(.RD_LATENCY(RD_LATENCY), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .reg_en_o(reg_en_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_we_o(reg_we_o), .reg_rdata_i(reg_rdata_i), .reg_ready_i(reg_ready_i)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int n_xfer   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Target peripheral: word memory, programmable ready stall, data valid RD_LATENCY after accept.
  logic [31:0] tgt_mem [0:63];
  logic        mem_inited = 1'b0;
  int          tgt_stall = 0;
  int          en_cnt = 0, en_total = 0, acc_total = 0;
  logic [31:0] acc_addr = '0, acc_wdata = '0;
  logic        acc_we = 1'b0;
  logic [2:0]  since = '0;
  logic [31:0] pend = '0, junk = '0;

  assign reg_ready_i = (en_cnt >= tgt_stall);
  assign reg_rdata_i = (RD_LATENCY == 0) ? tgt_mem[reg_addr_o[7:2]]
                     : ((int'(since) == RD_LATENCY) ? pend : junk);

  always @(posedge clk) begin
    junk <= $urandom;
    if (!rstn && !mem_inited) begin
      for (int i = 0; i < 64; i++) tgt_mem[i] <= 32'hC0DE_0000 + 32'(i * 7);
      mem_inited <= 1'b1;
    end
    en_cnt <= reg_en_o ? en_cnt + 1 : 0;
    if (reg_en_o) en_total <= en_total + 1;
    if (reg_en_o && reg_ready_i) begin
      acc_total <= acc_total + 1;
      acc_addr  <= reg_addr_o;
      acc_we    <= reg_we_o;
      acc_wdata <= reg_wdata_o;
      if (reg_we_o) tgt_mem[reg_addr_o[7:2]] <= reg_wdata_o;
      else begin
        pend  <= tgt_mem[reg_addr_o[7:2]];
        since <= 3'd1;
      end
    end else if (since != 3'd0 && since != 3'd7) begin
      since <= since + 3'd1;
    end
  end

  // Reference model: what the peripheral should hold after every completed write.
  logic [31:0] ref_mem [0:63];

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int stall);
    int en0, acc0, cyc, exp_cyc, exp_en, exp_acc;
    logic err, tmo, ok;
    logic [31:0] exp_rd;
    @(negedge clk);
    en0 = en_total; acc0 = acc_total; tgt_stall = stall;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    err = (addr[1:0] != 2'b00) || (wr && strb != 4'hF);
    tmo = !err && (TIMEOUT > 0) && (stall >= TIMEOUT);
    ok  = !err && !tmo;
    exp_cyc = err ? 1 : (tmo ? 1 + TIMEOUT : stall + 2 + (wr ? 0 : RD_LATENCY));
    exp_en  = err ? 0 : (tmo ? TIMEOUT : stall + 1);
    exp_acc = ok ? 1 : 0;
    exp_rd  = (ok && !wr) ? ref_mem[addr[7:2]] : 32'h0;
    if (ok && wr) ref_mem[addr[7:2]] = wdata;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      penable = 1'b1;
      if (!pready_o) begin
        check("wait_prdata", prdata_o, 32'h0);
        check("wait_pslverr", {31'b0, pslverr_o}, 32'h0);
      end
    end while (!pready_o && cyc < 200);
    check("latency", 32'(cyc), 32'(exp_cyc));
    check("pslverr", {31'b0, pslverr_o}, {31'b0, !ok});
    check("prdata", prdata_o, exp_rd);
    check("req_cycles", 32'(en_total - en0), 32'(exp_en));
    check("req_accepts", 32'(acc_total - acc0), 32'(exp_acc));
    if (ok) begin
      check("req_addr", acc_addr, addr);
      check("req_we", {31'b0, acc_we}, {31'b0, wr});
      if (wr) check("req_wdata", acc_wdata, wdata);
    end
    n_xfer++;
    $display("xfer %0d: %s addr=%08h wdata=%08h strb=%h stall=%0d -> prdata=%08h err=%0d cyc=%0d",
             n_xfer, wr ? "WR" : "RD", addr, wdata, strb, stall, prdata_o, pslverr_o, cyc);
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pready"}, {31'b0, pready_o}, 32'h0);
    check({tag, "_pslverr"}, {31'b0, pslverr_o}, 32'h0);
    check({tag, "_prdata"}, prdata_o, 32'h0);
    check({tag, "_reg_en"}, {31'b0, reg_en_o}, 32'h0);
    check({tag, "_reg_we"}, {31'b0, reg_we_o}, 32'h0);
    check({tag, "_reg_addr"}, reg_addr_o, 32'h0);
    check({tag, "_reg_wdata"}, reg_wdata_o, 32'h0);
  endtask

  initial begin
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    int          stall;
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i * 7);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;

    // Directed transfers
    xfer(1'b1, 32'h18, 32'h1234_5678, 4'hF, 0); idle();
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0); idle();
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 0); idle();
    xfer(1'b0, 32'h1A, 32'h0, 4'hF, 0); idle();
    xfer(1'b1, 32'h1A, 32'h5555_AAAA, 4'hF, 0); idle();
    xfer(1'b1, 32'h20, 32'h0BAD_F00D, 4'h3, 0); idle();
    xfer(1'b0, 32'h24, 32'h0, 4'hF, 100); idle();
    xfer(1'b1, 32'h24, 32'h7777_1111, 4'hF, 100); idle();
    xfer(1'b1, 32'h28, 32'hCAFE_0003, 4'hF, 3); idle();
    xfer(1'b0, 32'h28, 32'h0, 4'hF, 3); idle();
    xfer(1'b0, 32'h18, 32'h0, 4'hF, TIMEOUT - 1); idle();
    xfer(1'b1, 32'h30, 32'h600D_CAFE, 4'hF, 0);
    xfer(1'b0, 32'h30, 32'h0, 4'hF, 0);
    xfer(1'b0, 32'h1C, 32'h0, 4'hF, 0); idle();

    // Reset asserted while the bridge waits for read data
    @(negedge clk);
    tgt_stall = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h18; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    xfer(1'b0, 32'h18, 32'h0, 4'hF, 0); idle();
    xfer(1'b1, 32'h18, 32'hA1B2_C3D4, 4'hF, 0);
    xfer(1'b0, 32'h18, 32'h0, 4'hF, 0); idle();

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      strb = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      stall = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 4)
                                          : $urandom_range(0, 4);
      xfer(wr, addr, $urandom, strb, stall);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/apb_reg_bridge.md
Name: apb_reg_bridge

Overview:
- APB3 completer that converts each APB transfer into one single-beat request on the simple register port (reg_en/addr/wdata/we, rdata/ready) used by the subsystem peripherals, e.g. the CLINT timer.
- Sits directly upstream of the peripheral, between the subsystem APB fabric and one register-port target.
- Absorbs the target's registered read-data latency with APB wait states, and flags misaligned, partial-strobe or timed-out accesses with PSLVERR.

Parameters:
- RD_LATENCY, 1, cycles from request acceptance until reg_rdata_i is valid; legal range 0..3.
- TIMEOUT, 16, max consecutive cycles reg_ready_i may stay low while reg_en_o is high before aborting; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  APB write
- paddr_i  in  32  APB address
- pwdata_i  in  32  APB write data
- pstrb_i  in  4  APB write strobes
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- reg_en_o  out  1  register request
- reg_addr_o  out  32  register address
- reg_wdata_o  out  32  register write data
- reg_we_o  out  1  register write enable
- reg_rdata_i  in  32  register read data
- reg_ready_i  in  1  register request accepted

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; counters are 0.
- IDLE:
  - On psel_i=1 with penable_i=0 sampled at a clock edge, latch paddr/pwdata/pwrite/pstrb.
  - Error check on the latched transfer: paddr[1:0]!=0, or (pwrite=1 and pstrb!=4'hF), is an error.
  - Error: go to DONE with err=1; no register access is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive reg_en_o=1, reg_addr_o=latched addr, reg_wdata_o=latched data, reg_we_o=latched pwrite.
  - Acceptance is reg_en_o=1 and reg_ready_i=1 at a clock edge.
  - Accepted write: go to DONE.
  - Accepted read with RD_LATENCY=0: capture reg_rdata_i at the acceptance edge, then go to DONE.
  - Accepted read with RD_LATENCY>0: go to RDWAIT with the latency counter at 1.
  - reg_ready_i low: increment the stall counter. When it reaches TIMEOUT (TIMEOUT>0), go to DONE with err=1 and prdata=0; reg_en_o drops at that edge.
- RDWAIT:
  - Increment the counter each cycle.
  - At the edge where the counter equals RD_LATENCY, capture reg_rdata_i into prdata and go to DONE.
- DONE:
  - pready_o=1 and pslverr_o=err for exactly one cycle, then go to IDLE.
  - prdata_o holds the captured data on reads and is 0 on writes or errors.
  - prdata_o and pslverr_o are 0 whenever pready_o=0.
- reg_en_o is high only in ISSUE: at most one request per APB transfer, never a duplicate.
- Latency with reg_ready_i=1 and setup phase in cycle T0:
  - Write: pready_o high in T2 (one wait state).
  - Read: pready_o high in T2+RD_LATENCY.
  - Error: pready_o high in T1 (zero wait states).
- Back-to-back transfers: a setup phase in the cycle after DONE is accepted; there are no idle bubbles beyond the APB protocol itself.
- psel_i dropping before DONE is a protocol violation:
  - The FSM completes the in-flight sequence and returns to IDLE.
  - An already-issued reg write is not cancelled.
- Stall counter clears on every entry to ISSUE.
- Counters are sized to hold TIMEOUT and RD_LATENCY without wrap.
- Asynchronous reset mid-transfer:
  - Returns to IDLE and clears all outputs immediately.
  - A request in flight is dropped.

Test Plan:
- Write paddr=0x18, pwdata=0x1234_5678, pstrb=F, reg_ready_i=1 -> one-cycle reg_en_o with we=1, addr=0x18, wdata=0x12345678; pready_o in T2; pslverr_o=0.
- Read paddr=0x10, RD_LATENCY=1, target returns 0xDEAD_BEEF the cycle after acceptance -> prdata_o=0xDEADBEEF with pready_o in T3; reg_en_o high for exactly one cycle.
- Misaligned paddr=0x1A, or a write with pstrb=4'h3 -> reg_en_o never asserted; pready_o=1, pslverr_o=1 in T1; prdata_o=0.
- reg_ready_i held low, TIMEOUT=16 -> reg_en_o high for 16 cycles, then pready_o=1, pslverr_o=1, prdata_o=0. Repeat with reg_ready_i rising after 3 cycles -> normal completion, no error.
- Back-to-back write 0x18 then read 0x18 -> read returns the written value; each transfer produces exactly one reg_en_o pulse.
- rstn_i pulsed low while in RDWAIT -> all outputs 0 immediately; the next transfer completes normally with correct data.
